// File: rtl/horner_series_ctrl.sv
// Horner-rule sequencer: drives one shared registered multiply-add stage from coefficient
// index TERMS-1 down to 0. Build option SERIES_OVF_ABORT_EN stops at the first overflow and saturates.
module horner_series_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TERMS     = 8,
  parameter int ADDR_W    = 3,
  parameter int STAGE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  input  logic              abort,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [WIDTH-1:0]  lut_data,
  output logic              stage_en,
  output logic [WIDTH-1:0]  stage_prev,
  output logic [WIDTH-1:0]  stage_x,
  output logic [WIDTH-1:0]  stage_const,
  input  logic [WIDTH-1:0]  stage_out,
  input  logic              stage_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);

  localparam int CNT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(TERMS - 1);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(STAGE_LAT - 1);
  localparam logic [WIDTH-1:0]  SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                ovf_q, ovf_d;
  logic                ovf_stop;

`ifdef SERIES_OVF_ABORT_EN
  assign ovf_stop = stage_ovf;
`else
  assign ovf_stop = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    acc_d      = acc_q;
    x_d        = x_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        // Load happens on the accept edge; abort is irrelevant here.
        if (in_valid) begin
          x_d     = in_x;
          acc_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = LAST_IDX;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = WAIT_INIT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          acc_d      = '0;
          ovf_d      = 1'b0;
          idx_d      = '0;
          wait_cnt_d = '0;
          state_d    = S_IDLE;
        end else if (wait_cnt_q == '0) begin
          acc_d = stage_out;
          ovf_d = ovf_q | stage_ovf;
          if (ovf_stop) begin
            acc_d   = stage_out[WIDTH-1] ? SAT_NEG : SAT_POS;
            state_d = S_DONE;
          end else if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      x_q        <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q    <= state_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign stage_en    = (state_q == S_ISSUE);
  assign lut_addr    = idx_q;
  assign stage_prev  = acc_q;
  assign stage_x     = x_q;
  assign stage_const = lut_data;
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_valid ? acc_q : '0;
  assign res_ovf     = res_valid & ovf_q;

endmodule

// File: tb/tb_horner_series_ctrl.sv
// Scoreboard bench for horner_series_ctrl: two instances (STAGE_LAT 1 and 3) with a
// behavioural multiply-add stage, a coefficient LUT and a Horner reference model.
module tb_horner_series_ctrl;

  localparam int W    = 32;
  localparam int T    = 4;
  localparam int AW   = 3;
  localparam int NDUT = 2;

  typedef struct {
    int           d;
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   force_n = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] lut_mem [8];

  logic          in_valid  [NDUT];
  logic          in_ready  [NDUT];
  logic [W-1:0]  in_x      [NDUT];
  logic          abort_i   [NDUT];
  logic [AW-1:0] lut_addr  [NDUT];
  logic          stage_en  [NDUT];
  logic [W-1:0]  stage_prev[NDUT];
  logic [W-1:0]  stage_x   [NDUT];
  logic [W-1:0]  stage_const[NDUT];
  logic          res_valid [NDUT];
  logic          res_ready [NDUT];
  logic [W-1:0]  res_data  [NDUT];
  logic          res_ovf   [NDUT];
  logic          busy      [NDUT];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Signed multiply-add; overflow when the exact result does not fit in W signed bits.
  function automatic logic [W-1:0] mac_res(input logic [W-1:0] p, input logic [W-1:0] x,
                                           input logic [W-1:0] c);
    longint full;
    full = longint'($signed(p)) * longint'($signed(x)) + longint'($signed(c));
    return full[W-1:0];
  endfunction

  function automatic logic mac_ovf(input logic [W-1:0] p, input logic [W-1:0] x,
                                   input logic [W-1:0] c);
    longint       full;
    logic [W-1:0] lo;
    full = longint'($signed(p)) * longint'($signed(x)) + longint'($signed(c));
    lo   = full[W-1:0];
    return full != longint'($signed(lo));
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [W-1:0] lut_data_w;
    logic [W-1:0] stage_out_w;
    logic         stage_ovf_w;
    logic [W-1:0] pd [LAT];
    logic         pv [LAT];
    logic         po [LAT];
    int           n_iss;

    assign lut_data_w  = lut_mem[lut_addr[g]];
    // Outside the valid slot the stage shows junk, so a mistimed capture is visible.
    assign stage_out_w = pv[LAT-1] ? pd[LAT-1] : 32'hDEAD_BEEF;
    assign stage_ovf_w = pv[LAT-1] ? po[LAT-1] : 1'b1;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        n_iss <= 0;
        for (int i = 0; i < LAT; i++) begin
          pv[i] <= 1'b0;
          po[i] <= 1'b0;
          pd[i] <= '0;
        end
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          pd[i] <= pd[i-1];
          pv[i] <= pv[i-1];
          po[i] <= po[i-1];
        end
        pv[0] <= stage_en[g];
        pd[0] <= mac_res(stage_prev[g], stage_x[g], stage_const[g]);
        po[0] <= mac_ovf(stage_prev[g], stage_x[g], stage_const[g]) || (n_iss + 1 == force_n);
        if (in_valid[g] && in_ready[g]) n_iss <= 0;
        else if (stage_en[g])           n_iss <= n_iss + 1;
      end
    end

    horner_series_ctrl #(
      .WIDTH(W), .TERMS(T), .ADDR_W(AW), .STAGE_LAT(LAT)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_x       (in_x[g]),
      .abort      (abort_i[g]),
      .lut_addr   (lut_addr[g]),
      .lut_data   (lut_data_w),
      .stage_en   (stage_en[g]),
      .stage_prev (stage_prev[g]),
      .stage_x    (stage_x[g]),
      .stage_const(stage_const[g]),
      .stage_out  (stage_out_w),
      .stage_ovf  (stage_ovf_w),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_data   (res_data[g]),
      .res_ovf    (res_ovf[g]),
      .busy       (busy[g])
    );
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Horner evaluation straight from the coefficient list: acc = acc*x + c[i], i = T-1..0.
  task automatic ref_eval(input logic [W-1:0] x, input int fn, output logic [W-1:0] res,
                          output logic ovf, output int issues);
    logic [W-1:0] acc;
    logic         o;
    acc = '0; ovf = 1'b0; issues = 0;
    for (int i = T - 1; i >= 0; i--) begin
      issues++;
      o   = mac_ovf(acc, x, lut_mem[i]) || (issues == fn);
      acc = mac_res(acc, x, lut_mem[i]);
      ovf = ovf | o;
`ifdef SERIES_OVF_ABORT_EN
      if (o) begin
        acc = acc[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        break;
      end
`endif
    end
    res = acc;
  endtask

  task automatic set_lut(input logic [W-1:0] c0, input logic [W-1:0] c1,
                         input logic [W-1:0] c2, input logic [W-1:0] c3);
    lut_mem[0] = c0; lut_mem[1] = c1; lut_mem[2] = c2; lut_mem[3] = c3;
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_in_ready",   in_ready[d],   1);
    check("rst_res_valid",  res_valid[d],  0);
    check("rst_res_data",   res_data[d],   0);
    check("rst_res_ovf",    res_ovf[d],    0);
    check("rst_stage_en",   stage_en[d],   0);
    check("rst_busy",       busy[d],       0);
    check("rst_lut_addr",   lut_addr[d],   0);
    check("rst_stage_prev", stage_prev[d], 0);
    check("rst_stage_x",    stage_x[d],    0);
  endtask

  // One evaluation: push expectation, accept, time the result, hold it, then consume.
  task automatic run(input int d, input logic [W-1:0] x, input int fn, input int hold);
    logic [W-1:0]  er, held;
    logic          eo;
    int            ni, lat, step;
    int            en_lat[$];
    logic [AW-1:0] addrs[$];
    ref_eval(x, fn, er, eo, ni);
    force_n = fn;
    step = 1 + lat_of(d);
    @(negedge clk);
    check("in_ready_idle", in_ready[d], 1);
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    sb.push_back('{d, er, eo});
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_x[d]     = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      if (stage_en[d]) begin
        en_lat.push_back(lat);
        addrs.push_back(lut_addr[d]);
      end
      if (res_valid[d] || lat >= 200) break;
      @(posedge clk);
      lat++;
    end
    if (!res_valid[d]) begin
      check("res_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, ni * step);
    check("issue_count", en_lat.size(), ni);
    for (int k = 0; k < en_lat.size() && k < ni; k++) begin
      check("issue_spacing", en_lat[k], k * step);
      check("lut_addr_seq", addrs[k], T - 1 - k);
    end
    held = res_data[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid[d], 1);
      check("hold_data", res_data[d], held);
      check("hold_in_ready", in_ready[d], 0);
    end
    res_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready[d] = 1'b0;
    check("valid_drop", res_valid[d], 0);
    check("back_idle", in_ready[d], 1);
  endtask

  task automatic run_abort(input int d, input logic [W-1:0] x);
    int n, k;
    force_n = 0;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    n = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (stage_en[d]) n++;
      if (n == 2 && !stage_en[d]) break;
      k++;
    end
    check("abort_reached_wait", n, 2);
    abort_i[d] = 1'b1;
    @(negedge clk);
    abort_i[d] = 1'b0;
    check("abort_in_ready", in_ready[d], 1);
    check("abort_busy", busy[d], 0);
    check("abort_acc_clear", stage_prev[d], 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", res_valid[d], 0);
    end
  endtask

  task automatic run_reset(input int d, input logic [W-1:0] x);
    int n, k;
    force_n = 0;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    n = 0; k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (stage_en[d]) n++;
      if (n == 3) break;
      k++;
    end
    check("reset_reached_issue3", n, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(d);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", in_ready[d], 1);
  endtask

  function automatic logic [W-1:0] rand_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return W'($urandom_range(0, 20)) - 32'd10;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) begin
        if (rst_n && res_valid[g] && res_ready[g]) begin
          if (sb.size() == 0) begin
            check("unexpected_result", res_data[g], 'x);
          end else begin
            e = sb.pop_front();
            check("sb_instance", g, e.d);
            check("sb_res_data", res_data[g], e.data);
            check("sb_res_ovf", res_ovf[g], e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int d, fn, hold;
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g] = 1'b0; in_x[g] = '0; abort_i[g] = 1'b0; res_ready[g] = 1'b0;
    end
    for (int i = 0; i < 8; i++) lut_mem[i] = '0;
    set_lut(1, 1, 1, 1);
    #12;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 2, 0, 0);                       // all-ones LUT, x=2 -> 15
    set_lut(5, 0, 3, 2);
    run(0, 3, 0, 5);                       // 2, 9, 27, 86 with back-pressure
    set_lut(1, 1, 1, 1);
    run(0, 2, 2, 0);                       // forced overflow on the 2nd capture
    run_abort(0, 2);
    run(0, 2, 0, 0);
    run_reset(0, 2);
    run(0, 2, 0, 1);
    run(1, 1, 0, 2);                       // STAGE_LAT=3, x=1 -> 4
    run_abort(1, 3);
    run(1, 2, 0, 0);

    for (int i = 0; i < 24; i++) begin
      d = i % 2;
      for (int j = 0; j < T; j++) lut_mem[j] = rand_val();
      fn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : 0;
      hold = $urandom_range(0, 3);
      run(d, rand_val(), fn, hold);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
